uart_rx_frame_timer: RTL and testbench

Parametrised oversampling timer for the UART receiver. It counts oversampling edges within each bit and bits within a frame. It also produces bit-done and frame-done strobes and a mid-bit (optionally majority-voted) data sample, so the RX FSM and deserializer no longer decode raw counters. It sits between the RX FSM (which drives `enable`) and the deserializer, parity check and stop check.

---
 rtl/uart_rx_frame_timer.sv | 115 +++++++++++
 tb/tb_uart_rx_frame_timer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_timer.sv
// Oversampling bit/frame timer for the UART receiver with mid-bit sampling.
// Define UART_RX_MAJORITY_EN for a 3-sample majority vote; the default is a single mid-bit sample.
module uart_rx_frame_timer #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [BIT_CNT_W-1:0]  frame_bits,
    input  logic                  RX_IN,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  busy,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  sampled_bit,
    output logic                  sample_valid
);

    localparam logic [PRESCALE_W-1:0] MIN_P = PRESCALE_W'(6);
    localparam logic [BIT_CNT_W-1:0]  MIN_F = BIT_CNT_W'(2);

    logic [PRESCALE_W-1:0] p_lat;
    logic [PRESCALE_W-1:0] p_eff;
    logic [PRESCALE_W-1:0] p_last;
    logic [PRESCALE_W-1:0] mid;
    logic [BIT_CNT_W-1:0]  f_lat;
    logic [BIT_CNT_W-1:0]  f_eff;
    logic [BIT_CNT_W-1:0]  f_last;
    logic                  last_edge;
    logic                  last_bit;
    logic                  sample_at;
    logic                  sample_val;

    // Until the parameters are latched the live (clamped) inputs set the timing.
    always_comb begin
        p_eff     = busy ? p_lat : ((Prescale < MIN_P) ? MIN_P : Prescale);
        f_eff     = busy ? f_lat : ((frame_bits < MIN_F) ? MIN_F : frame_bits);
        p_last    = p_eff - PRESCALE_W'(1);
        f_last    = f_eff - BIT_CNT_W'(1);
        mid       = p_eff >> 1;
        last_edge = (edge_cnt == p_last);
        last_bit  = (bit_cnt == f_last);
    end

    assign bit_done   = enable & last_edge;
    assign frame_done = bit_done & last_bit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            p_lat    <= MIN_P;
            f_lat    <= MIN_F;
        end else if (!enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
        end else begin
            if (!busy) begin
                p_lat <= p_eff;
                f_lat <= f_eff;
                busy  <= 1'b1;
            end
            if (last_edge) begin
                edge_cnt <= '0;
                bit_cnt  <= last_bit ? '0 : bit_cnt + BIT_CNT_W'(1);
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic vote_a;
    logic vote_b;

    // Early and centre captures; the third sample is taken live at mid+1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vote_a <= 1'b0;
            vote_b <= 1'b0;
        end else if (!enable) begin
            vote_a <= 1'b0;
            vote_b <= 1'b0;
        end else begin
            if (edge_cnt == mid - PRESCALE_W'(1)) vote_a <= RX_IN;
            if (edge_cnt == mid) vote_b <= RX_IN;
        end
    end

    assign sample_at  = (edge_cnt == mid + PRESCALE_W'(1));
    assign sample_val = (vote_a & vote_b) | (vote_a & RX_IN) | (vote_b & RX_IN);
`else
    assign sample_at  = (edge_cnt == mid);
    assign sample_val = RX_IN;
`endif

    // sampled_bit keeps its last value across an abort; only the strobe is cleared.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sampled_bit  <= 1'b0;
            sample_valid <= 1'b0;
        end else if (!enable) begin
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= sample_at;
            if (sample_at) sampled_bit <= sample_val;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Randomized self-checking bench for uart_rx_frame_timer against a cycle-count reference model.
// Honours UART_RX_MAJORITY_EN to pick the expected sampling rule.
module tb_uart_rx_frame_timer;

`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       enable;
    logic [5:0] Prescale;
    logic [3:0] frame_bits;
    logic       RX_IN;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       busy;
    logic       bit_done;
    logic       frame_done;
    logic       sampled_bit;
    logic       sample_valid;

    int   numChecks = 0;
    int   numFails  = 0;

    // Model state: enabled cycles completed in the current run, run parameters, recent RX history.
    int   n = 0;
    int   runP = 6;
    int   runF = 2;
    logic rx1 = 1'b0;
    logic rx2 = 1'b0;
    logic rx3 = 1'b0;
    logic expSampled = 1'b0;

    uart_rx_frame_timer #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .Prescale(Prescale),
        .frame_bits(frame_bits), .RX_IN(RX_IN), .edge_cnt(edge_cnt),
        .bit_cnt(bit_cnt), .busy(busy), .bit_done(bit_done),
        .frame_done(frame_done), .sampled_bit(sampled_bit),
        .sample_valid(sample_valid)
    );

    always #5 CLK = ~CLK;

    function automatic int clampP(input int x);
        return (x < 6) ? 6 : x;
    endfunction

    function automatic int clampF(input int x);
        return (x < 2) ? 2 : x;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t, run cycle %0d)", tag, actual, expected, $time, n);
        end
    endtask

    // One clock cycle: drive inputs, optionally pulse reset, then check all outputs mid-cycle.
    task automatic applyStimulus(input logic en, input int pre, input int fb, input logic rx, input bit doReset);
        int   edgeE;
        int   bitE;
        int   midE;
        int   sampleEdge;
        logic busyE;
        logic bdE;
        logic fdE;
        logic svE;
        @(posedge CLK);
        #1;
        enable     = en;
        Prescale   = pre[5:0];
        frame_bits = fb[3:0];
        RX_IN      = rx;
        if (doReset) begin
            #1 RST = 1'b1;
            #1;
            checkOutput("async_rst_edge_cnt", edge_cnt, 0);
            checkOutput("async_rst_bit_cnt", bit_cnt, 0);
            checkOutput("async_rst_busy", busy, 0);
            checkOutput("async_rst_sample_valid", sample_valid, 0);
            checkOutput("async_rst_sampled_bit", sampled_bit, 0);
            #1 RST = 1'b0;
            n = 0;
            expSampled = 1'b0;
        end
        if (n == 0 && en) begin
            runP = clampP(pre[5:0]);
            runF = clampF(fb[3:0]);
        end
        edgeE      = n % runP;
        bitE       = (n / runP) % runF;
        busyE      = (n > 0);
        midE       = runP / 2;
        sampleEdge = MAJ ? midE + 2 : midE + 1;
        svE        = (n > 0) && (edgeE == sampleEdge);
        if (svE) expSampled = MAJ ? ((rx3 & rx2) | (rx3 & rx1) | (rx2 & rx1)) : rx1;
        bdE        = en && (edgeE == runP - 1);
        fdE        = bdE && (bitE == runF - 1);
        @(negedge CLK);
        checkOutput("edge_cnt", edge_cnt, edgeE);
        checkOutput("bit_cnt", bit_cnt, bitE);
        checkOutput("busy", busy, busyE);
        checkOutput("bit_done", bit_done, bdE);
        checkOutput("frame_done", frame_done, fdE);
        checkOutput("sample_valid", sample_valid, svE);
        checkOutput("sampled_bit", sampled_bit, expSampled);
        rx3 = rx2;
        rx2 = rx1;
        rx1 = rx;
        n   = en ? n + 1 : 0;
    endtask

    initial begin
        int   pre;
        int   fb;
        logic en;
        bit   rst;
        RST        = 1'b1;
        enable     = 1'b0;
        Prescale   = 6'd8;
        frame_bits = 4'd10;
        RX_IN      = 1'b0;
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;

        // Reset state
        repeat (3) applyStimulus(1'b0, 8, 10, 1'b0, 1'b0);

        // Basic count across two full frames and the wrap
        for (int i = 0; i < 170; i++) applyStimulus(1'b1, 8, 10, 1'($urandom % 2), 1'b0);

        // Abort at bit 4, edge 5
        applyStimulus(1'b0, 8, 10, 1'b0, 1'b0);
        for (int i = 0; i < 37; i++) applyStimulus(1'b1, 8, 10, 1'($urandom % 2), 1'b0);
        repeat (2) applyStimulus(1'b0, 8, 10, 1'b1, 1'b0);

        // Clamping of tiny prescale and frame length
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 3, 1, 1'($urandom % 2), 1'b0);
        applyStimulus(1'b0, 3, 1, 1'b0, 1'b0);

        // Parameter latch, then re-latch after a one-cycle drop
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8, 10, 1'($urandom % 2), 1'b0);
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 16, 10, 1'($urandom % 2), 1'b0);
        applyStimulus(1'b0, 16, 10, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 16, 10, 1'($urandom % 2), 1'b0);

        // Async reset in the middle of a frame
        for (int i = 0; i < 13; i++) applyStimulus(1'b1, 8, 10, 1'($urandom % 2), 1'b0);
        applyStimulus(1'b1, 8, 10, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8, 10, 1'($urandom % 2), 1'b0);

        // Randomized enables, parameters, line data and resets
        pre = 8;
        fb  = 10;
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 19) == 0) begin
                pre = $urandom_range(0, 20);
                fb  = $urandom_range(0, 12);
            end
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus(en, pre, fb, 1'($urandom % 2), rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
